// File: rtl/ecg_dual_lif_encoder.sv
// Two-polarity leaky integrate-and-fire spike encoder for signed ECG samples.
// ON channel integrates positive deflections, OFF channel integrates negative ones.
module ecg_dual_lif_encoder #(
    parameter int unsigned W          = 20,
    parameter int unsigned ACC_W      = 24,
    parameter int unsigned THRESH     = 1000,
    parameter int unsigned LEAK_SHIFT = 4,
    parameter int unsigned REFRAC     = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic signed [W-1:0] sample,
    input  logic                count_clr,
    output logic                spike_pos,
    output logic                spike_neg,
    output logic                spike_any,
    output logic [ACC_W-1:0]    vmem_pos,
    output logic [ACC_W-1:0]    vmem_neg,
    output logic [CNT_W-1:0]    count_pos,
    output logic [CNT_W-1:0]    count_neg
);

    localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [ACC_W:0]  THR      = (ACC_W+1)'(THRESH);
    localparam logic [ACC_W:0]  SAT      = {1'b0, {ACC_W{1'b1}}};
    localparam logic [RW-1:0]   REFRAC_V = RW'(REFRAC);
    localparam logic [W-1:0]    S_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]    S_MAX    = {1'b0, {(W-1){1'b1}}};

    // index 0 = ON channel, index 1 = OFF channel
    logic [1:0][ACC_W-1:0] v_q;
    logic [1:0][RW-1:0]    refr_q;
    logic [1:0][CNT_W-1:0] cnt_q;
    logic [1:0]            spk_q;

    logic [W-1:0]          mag_neg;
    logic [1:0][ACC_W-1:0] in_c;
    logic [1:0][ACC_W-1:0] leak_c;
    logic [1:0][ACC_W-1:0] vl_c;
    logic [1:0][ACC_W:0]   sum_c;
    logic [1:0][ACC_W:0]   t_c;
    logic [1:0]            fire_c;
    logic [1:0][ACC_W-1:0] v_n;
    logic [1:0][RW-1:0]    refr_n;

    // Rectification; the most negative sample clamps to the largest positive magnitude
    always_comb begin
        mag_neg = (sample == S_MIN) ? S_MAX : (~sample + W'(1));
        in_c[0] = sample[W-1] ? '0 : {{(ACC_W-W){1'b0}}, sample};
        in_c[1] = sample[W-1] ? {{(ACC_W-W){1'b0}}, mag_neg} : '0;
    end

    // Per-channel leak, saturating integrate, threshold and refractory update
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            leak_c[c] = (LEAK_SHIFT == 0) ? '0 : (v_q[c] >> LEAK_SHIFT);
            vl_c[c]   = v_q[c] - leak_c[c];
            sum_c[c]  = {1'b0, vl_c[c]} + {1'b0, in_c[c]};
            t_c[c]    = (sum_c[c] > SAT) ? SAT : sum_c[c];
            fire_c[c] = 1'b0;
            v_n[c]    = vl_c[c];
            refr_n[c] = refr_q[c];
            if (refr_q[c] != '0) begin
                refr_n[c] = refr_q[c] - RW'(1);
            end else if (t_c[c] >= THR) begin
                fire_c[c] = 1'b1;
                v_n[c]    = ACC_W'(t_c[c] - THR);
                refr_n[c] = REFRAC_V;
            end else begin
                v_n[c]    = ACC_W'(t_c[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            refr_q <= '0;
            cnt_q  <= '0;
            spk_q  <= '0;
        end else begin
            spk_q <= sample_valid ? fire_c : 2'b00;
            if (sample_valid) begin
                v_q    <= v_n;
                refr_q <= refr_n;
            end
            // Clear wins over a same-edge increment; the spike itself still pulses
            for (int c = 0; c < 2; c++) begin
                if (count_clr)
                    cnt_q[c] <= '0;
                else if (sample_valid && fire_c[c] && (cnt_q[c] != {CNT_W{1'b1}}))
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
            end
        end
    end

    assign spike_pos = spk_q[0];
    assign spike_neg = spk_q[1];
    assign spike_any = spk_q[0] | spk_q[1];
    assign vmem_pos  = v_q[0];
    assign vmem_neg  = v_q[1];
    assign count_pos = cnt_q[0];
    assign count_neg = cnt_q[1];

endmodule

// File: tb/tb_ecg_dual_lif_encoder.sv
// Scoreboard bench for ecg_dual_lif_encoder: four configurations share one stimulus stream.
module tb_ecg_dual_lif_encoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sample_valid = 1'b0;
    logic signed [19:0] sample = '0;
    logic count_clr = 1'b0;

    always #5 clk = ~clk;

    // a: no leak, no refractory, 4-bit counters; b: leak 1; c: refractory 2; d: max threshold
    logic a_sp, a_sn, a_any, b_sp, b_sn, b_any, c_sp, c_sn, c_any, d_sp, d_sn, d_any;
    logic [23:0] a_vp, a_vn, b_vp, b_vn, c_vp, c_vn, d_vp, d_vn;
    logic [3:0]  a_cp, a_cn;
    logic [15:0] b_cp, b_cn, c_cp, c_cn, d_cp, d_cn;

    ecg_dual_lif_encoder #(.THRESH(1000), .LEAK_SHIFT(0), .REFRAC(0), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .count_clr(count_clr),
        .spike_pos(a_sp), .spike_neg(a_sn), .spike_any(a_any), .vmem_pos(a_vp), .vmem_neg(a_vn),
        .count_pos(a_cp), .count_neg(a_cn));
    ecg_dual_lif_encoder #(.THRESH(1000), .LEAK_SHIFT(1), .REFRAC(0)) u_b (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .count_clr(count_clr),
        .spike_pos(b_sp), .spike_neg(b_sn), .spike_any(b_any), .vmem_pos(b_vp), .vmem_neg(b_vn),
        .count_pos(b_cp), .count_neg(b_cn));
    ecg_dual_lif_encoder #(.THRESH(1000), .LEAK_SHIFT(0), .REFRAC(2)) u_c (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .count_clr(count_clr),
        .spike_pos(c_sp), .spike_neg(c_sn), .spike_any(c_any), .vmem_pos(c_vp), .vmem_neg(c_vn),
        .count_pos(c_cp), .count_neg(c_cn));
    ecg_dual_lif_encoder #(.THRESH(16777215), .LEAK_SHIFT(0), .REFRAC(0)) u_d (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .count_clr(count_clr),
        .spike_pos(d_sp), .spike_neg(d_sn), .spike_any(d_any), .vmem_pos(d_vp), .vmem_neg(d_vn),
        .count_pos(d_cp), .count_neg(d_cn));

    typedef struct {
        logic        sp;
        logic        sn;
        logic [23:0] vp;
        logic [23:0] vn;
        logic [15:0] cp;
        logic [15:0] cn;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    task automatic push(input int sp, input int sn, input int vp, input int vn, input int cp, input int cn);
        exp_t x;
        x.sp = 1'(sp); x.sn = 1'(sn);
        x.vp = 24'(vp); x.vn = 24'(vn);
        x.cp = 16'(cp); x.cn = 16'(cn);
        sb.push_back(x);
    endtask

    task automatic drive(input logic v, input int s, input logic clr, input logic rst);
        sample_valid = v;
        sample       = 20'(s);
        count_clr    = clr;
        reset        = rst;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        count_clr    = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic pop_exp(input string tag);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s scoreboard empty", tag);
            e = '{1'b0, 1'b0, 24'd0, 24'd0, 16'd0, 16'd0};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 250, 1'b0, 1'b1);
        checks++;
        if ({a_sp, a_sn, a_any, a_vp, a_vn, a_cp, a_cn, b_sp, b_sn, b_any, b_vp, b_vn, b_cp, b_cn} !== '0) begin
            errors++;
            $display("FAIL reset_ab got a=%b%b%b %0d %0d %0d %0d b=%b%b%b %0d %0d %0d %0d required all 0",
                     a_sp, a_sn, a_any, a_vp, a_vn, a_cp, a_cn, b_sp, b_sn, b_any, b_vp, b_vn, b_cp, b_cn);
        end
        checks++;
        if ({c_sp, c_sn, c_any, c_vp, c_vn, c_cp, c_cn, d_sp, d_sn, d_any, d_vp, d_vn, d_cp, d_cn} !== '0) begin
            errors++;
            $display("FAIL reset_cd got c=%b%b%b %0d %0d %0d %0d d=%b%b%b %0d %0d %0d %0d required all 0",
                     c_sp, c_sn, c_any, c_vp, c_vn, c_cp, c_cn, d_sp, d_sn, d_any, d_vp, d_vn, d_cp, d_cn);
        end
    endtask

    // Pop one expectation and compare instance a
    task automatic check_a(input string tag);
        pop_exp(tag);
        checks++;
        if ({a_sp, a_sn, a_any} !== {e.sp, e.sn, e.sp | e.sn}) begin
            errors++;
            $display("FAIL %s spikes got %b%b%b required %b%b%b", tag, a_sp, a_sn, a_any, e.sp, e.sn, e.sp | e.sn);
        end
        checks++;
        if ({a_vp, a_vn, 16'(a_cp), 16'(a_cn)} !== {e.vp, e.vn, e.cp, e.cn}) begin
            errors++;
            $display("FAIL %s state got vp=%0d vn=%0d cp=%0d cn=%0d required vp=%0d vn=%0d cp=%0d cn=%0d",
                     tag, a_vp, a_vn, a_cp, a_cn, e.vp, e.vn, e.cp, e.cn);
        end
    endtask

    task automatic test_integrate();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            push((i % 4) == 0, 0, (i * 250) % 1000, 0, i / 4, 0);
            drive(1'b1, 250, 1'b0, 1'b0);
            check_a($sformatf("integrate[%0d]", i));
        end
        checks++;
        if (a_cp !== 4'd3) begin
            errors++;
            $display("FAIL integrate_count got %0d required 3", a_cp);
        end
    endtask

    task automatic test_off_leak();
        int vn_exp[3] = '{600, 900, 50};
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push(0, i == 2, 0, vn_exp[i], 0, i == 2);
            drive(1'b1, -600, 1'b0, 1'b0);
            pop_exp("off_leak");
            checks++;
            if ({b_sp, b_sn, b_any, b_vp, b_vn, b_cp, b_cn} !== {e.sp, e.sn, e.sp | e.sn, e.vp, e.vn, e.cp, e.cn}) begin
                errors++;
                $display("FAIL off_leak[%0d] got sp=%b sn=%b any=%b vp=%0d vn=%0d cn=%0d required sn=%b vn=%0d cn=%0d",
                         i, b_sp, b_sn, b_any, b_vp, b_vn, b_cn, e.sn, e.vn, e.cn);
            end
        end
    endtask

    task automatic check_c(input string tag);
        pop_exp(tag);
        checks++;
        if ({c_sp, c_sn, c_any, c_vp, c_vn, c_cp} !== {e.sp, e.sn, e.sp | e.sn, e.vp, e.vn, e.cp}) begin
            errors++;
            $display("FAIL %s got sp=%b sn=%b any=%b vp=%0d vn=%0d cp=%0d required sp=%b vp=%0d cp=%0d",
                     tag, c_sp, c_sn, c_any, c_vp, c_vn, c_cp, e.sp, e.vp, e.cp);
        end
    endtask

    task automatic test_refractory();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            push(i == 1 || i == 4 || i == 7, 0, 0, 0, (i + 2) / 3, 0);
            drive(1'b1, 1000, 1'b0, 1'b0);
            check_c($sformatf("refrac[%0d]", i));
        end
        // Idle cycles must not consume refractory time
        drive(1'b0, 0, 1'b0, 1'b1);
        push(1, 0, 0, 0, 1, 0);
        drive(1'b1, 1000, 1'b0, 1'b0);
        check_c("refgap_s1");
        for (int i = 0; i < 5; i++) begin
            push(0, 0, 0, 0, 1, 0);
            drive(1'b0, 1000, 1'b0, 1'b0);
            check_c($sformatf("refgap_idle[%0d]", i));
        end
        for (int i = 2; i <= 4; i++) begin
            push(i == 4, 0, 0, 0, (i == 4) ? 2 : 1, 0);
            drive(1'b1, 1000, 1'b0, 1'b0);
            check_c($sformatf("refgap_s%0d", i));
        end
    endtask

    task automatic test_saturation();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 33; i++) begin
            push(0, i == 33, 0, (i < 33) ? i * 524287 : 0, 0, i == 33);
            drive(1'b1, -524288, 1'b0, 1'b0);
            pop_exp("saturation");
            checks++;
            if ({d_sp, d_sn, d_any, d_vp, d_vn, d_cn} !== {e.sp, e.sn, e.sp | e.sn, e.vp, e.vn, e.cn}) begin
                errors++;
                $display("FAIL saturation[%0d] got sn=%b any=%b vp=%0d vn=%0d cn=%0d required sn=%b vn=%0d cn=%0d",
                         i, d_sn, d_any, d_vp, d_vn, d_cn, e.sn, e.vn, e.cn);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            push(1, 0, 0, 0, (i < 15) ? i : 15, 0);
            drive(1'b1, 1000, 1'b0, 1'b0);
            check_a($sformatf("b2b_sat[%0d]", i));
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            push(0, 0, i * 250, 0, 0, 0);
            drive(1'b1, 250, 1'b0, 1'b0);
            check_a($sformatf("rstmid_pre[%0d]", i));
        end
        push(0, 0, 0, 0, 0, 0);
        drive(1'b1, 250, 1'b0, 1'b1);
        check_a("rstmid_edge");
        for (int i = 1; i <= 4; i++) begin
            push(i == 4, 0, (i * 250) % 1000, 0, i == 4, 0);
            drive(1'b1, 250, 1'b0, 1'b0);
            check_a($sformatf("rstmid_post[%0d]", i));
        end
    endtask

    task automatic test_clear();
        drive(1'b0, 0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            push(i == 4, 0, (i * 250) % 1000, 0, i >= 4, 0);
            drive(1'b1, 250, 1'b0, 1'b0);
            check_a($sformatf("clear_pre[%0d]", i));
        end
        push(1, 0, 0, 0, 0, 0);
        drive(1'b1, 250, 1'b1, 1'b0);
        check_a("clear_fire");
        push(0, 0, 250, 0, 0, 0);
        drive(1'b1, 250, 1'b0, 1'b0);
        check_a("clear_after");
    endtask

    task automatic test_dual();
        drive(1'b0, 0, 1'b0, 1'b1);
        push(1, 0, 1500, 0, 1, 0);
        drive(1'b1, 2500, 1'b0, 1'b0);
        check_a("dual_s1");
        push(1, 1, 500, 1500, 2, 1);
        drive(1'b1, -2500, 1'b0, 1'b0);
        check_a("dual_s2");
        push(0, 1, 500, 500, 2, 2);
        drive(1'b1, 0, 1'b0, 1'b0);
        check_a("dual_s3");
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_off_leak();
        test_refractory();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_clear();
        test_dual();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d entries required 0", sb.size());
        end
        checks++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
